pkt_write_control: RTL and testbench
====================================

Name: pkt_write_control

Overview:
Per-interface writer into pkt_centralize_bufm_memory, on the ingress side of the chip. It prefetches one free pkt_bufid from the PCB and converts it to base write address {bufid,7'h0}. It then writes an incoming packet, one 134-bit word per line, into that 128-word buffer. On completion it hands a {bufid,length} descriptor to forwarding. Aborted packets return their bufid to the PCB.

Parameters:
DW, 134, packet word width; bit DW-1 = sop, bit DW-2 = eop
MAX_WORDS, 128, words per buffer (address low field is 7 bits)
REL_DEPTH, 4, depth of the release FIFO (power of 2)

Ports:
i_clk  in  1  125 MHz clock
i_rst_n  in  1  reset; single clock domain, asynchronous assert, active-low
iv_free_bufid  in  9  free bufid offered by PCB
i_free_bufid_wr  in  1  iv_free_bufid valid
o_free_bufid_ack  out  1  one-cycle pulse: offered bufid taken
iv_data  in  DW  packet word with sop/eop flags
i_data_wr  in  1  word valid; no backpressure
ov_pkt_data  out  DW  memory write data
ov_pkt_waddr  out  16  memory write address
o_pkt_wr  out  1  memory write strobe
ov_desc_bufid  out  9  completed-packet bufid
ov_desc_len  out  8  completed-packet word count (1..128)
o_desc_wr  out  1  descriptor valid; held until acknowledged
i_desc_ack  in  1  descriptor accepted
ov_rel_bufid  out  9  bufid returned to PCB
o_rel_bufid_wr  out  1  release valid; held until acknowledged
i_rel_bufid_ack  in  1  release accepted
ov_drop_cnt  out  16  dropped-packet counter; wraps
o_rel_overflow  out  1  sticky error: release FIFO was full
ov_pwc_state  out  2  current FSM state

Behaviour:
- Reset value of every output is 0. The bufid cache, descriptor register, release FIFO and FSM are cleared; FSM enters IDLE_S. Reset mid-packet discards all state, with no release.
- Bufid cache (valid bit + 9-bit id):
  - Loads when the cache is empty and i_free_bufid_wr=1.
  - o_free_bufid_ack pulses the next cycle.
  - Invalidated when consumed at sop.
  - A load and a consume in the same cycle is impossible: loading requires the cache to be empty.
- Memory write latency is 1 cycle. A word accepted at cycle N gives o_pkt_wr=1 at N+1 with registered data and address. There is no memory ack.
- FSM states: IDLE_S=0, WRITE_S=1, DISCARD_S=2.
- IDLE_S:
  - Word with sop and cache valid: write at {bufid,7'h0}, cnt=1, consume cache. If eop is also set, finish (see below) and stay in IDLE_S; otherwise go to WRITE_S.
  - Word with sop and cache empty: drop_cnt+1. If eop is not set, go to DISCARD_S.
  - Word without sop: ignored.
- WRITE_S, word without sop:
  - If cnt<128: write at address+1, cnt+1. If eop, finish and go to IDLE_S.
  - If cnt=128 (129th word): do not write, release bufid, drop_cnt+1. Go to IDLE_S if eop, else DISCARD_S.
- WRITE_S, word with sop: abort the current packet (release bufid, drop_cnt+1), then handle the same word with the IDLE_S rules in that cycle.
- DISCARD_S: nothing is written. Go to IDLE_S on eop. A sop word here is handled with the IDLE_S rules.
- Finish:
  - If the descriptor register is empty, or i_desc_ack=1 this cycle: load {bufid, cnt}, o_desc_wr=1 next cycle.
  - Otherwise: release bufid, drop_cnt+1.
- The descriptor register clears on i_desc_ack. A load in the same cycle takes priority.
- Release FIFO:
  - Push on every abort or drop that holds a bufid.
  - The head drives ov_rel_bufid/o_rel_bufid_wr; pop on i_rel_bufid_ack.
  - A push and pop in the same cycle is allowed.
  - A push when full is discarded and sets o_rel_overflow until reset.
- drop_cnt wraps 16'hFFFF to 0. At most one increment per cycle: when an abort is followed by a cache-empty sop in the same cycle, the count is +1 only.

Decomposition:
- Shared package: state encodings, MAX_WORDS, SOP/EOP bit indices, bufid/address widths. These are shared with pkt_read_control.
- One sub-module, pwc_release_fifo: synchronous FIFO of width 9 and depth REL_DEPTH, with full/empty and first-word fall-through.

Test Plan:
1. Offer bufid 0x05; send a 3-word packet -> ack pulse one cycle after the offer; writes at 0x0280, 0x0281, 0x0282; descriptor {0x05, 3}; no release.
2. Single word with sop+eop, bufid 0x1FF -> one write at 0xFF80; descriptor len=1; FSM stays in IDLE_S.
3. Cache empty, 4-word packet -> no writes; drop_cnt=1; DISCARD_S until eop. Offer bufid 0x07 mid-packet; the next packet is written at 0x0380.
4. 130-word packet with bufid 0x02 -> 128 writes 0x0100–0x017F; release 0x02; drop_cnt=1; no descriptor.
5. Descriptor held (i_desc_ack=0), second packet with bufid 0x09 completes -> release 0x09, drop_cnt+1, first descriptor unchanged. Ack while third packet's eop arrives -> new descriptor loads with no gap.
6. i_rel_bufid_ack=0, five aborts (new sop mid-packet) -> four releases queued, o_rel_overflow=1. Then assert reset mid-packet -> all outputs 0, state IDLE_S.

Source files
------------

// File: rtl/pkt_write_control_pkg.sv
// Shared definitions for the packet buffer writer and reader: FSM
// encodings, buffer geometry and the sop/eop flag positions.
package pkt_write_control_pkg;

   localparam int PKT_DW        = 134;  // default packet word width
   localparam int SOP_OFS       = 1;    // sop flag sits at DW-1
   localparam int EOP_OFS       = 2;    // eop flag sits at DW-2
   localparam int PKT_MAX_WORDS = 128;  // words per buffer
   localparam int OFS_W         = 7;    // word offset field of an address
   localparam int BUFID_W       = 9;
   localparam int ADDR_W        = 16;
   localparam int LEN_W         = 8;

   typedef enum logic [1:0] {
      IDLE_S    = 2'd0,
      WRITE_S   = 2'd1,
      DISCARD_S = 2'd2
   } pwc_state_e;

endpackage

// File: rtl/pwc_release_fifo.sv
// Release FIFO for bufids going back to the buffer manager. First-word
// fall-through; up to two pushes per cycle (an abort and a failed finish can
// coincide). Pushes that find no room are dropped and flagged on ovf.
module pwc_release_fifo #(
   parameter int W     = 9,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_a,
   input  logic [W-1:0] din_a,
   input  logic         push_b,
   input  logic [W-1:0] din_b,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         empty,
   output logic         ovf
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [PW-1:0] wptr_b;
   logic [PW:0]   count;
   logic          full;
   logic          acc_a;
   logic          acc_b;
   logic          do_pop;

   // Accept each push only if a slot is free at the start of the cycle.
   always_comb begin
      full   = (count == (PW+1)'(DEPTH));
      acc_a  = push_a && !full;
      acc_b  = push_b && ((count + (PW+1)'(acc_a)) < (PW+1)'(DEPTH));
      do_pop = pop && !empty;
      wptr_b = wptr + PW'(acc_a);
      ovf    = (push_a && !acc_a) || (push_b && !acc_b);
   end

   // Storage: push_a lands first, push_b behind it.
   always_ff @(posedge clk) begin
      if (acc_a) mem[wptr]   <= din_a;
      if (acc_b) mem[wptr_b] <= din_b;
   end

   // Pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         wptr  <= wptr + PW'(acc_a) + PW'(acc_b);
         rptr  <= rptr + PW'(do_pop);
         count <= count + (PW+1)'(acc_a) + (PW+1)'(acc_b) - (PW+1)'(do_pop);
      end
   end

   assign empty = (count == '0);
   assign dout  = empty ? '0 : mem[rptr];

endmodule

// File: rtl/pkt_write_control.sv
// Ingress packet writer: holds one prefetched bufid, writes a packet into
// its 128-word buffer, and hands {bufid,len} to forwarding or returns the
// bufid to the buffer manager when the packet cannot be kept.
module pkt_write_control
   import pkt_write_control_pkg::*;
#(
   parameter int DW        = PKT_DW,
   parameter int MAX_WORDS = PKT_MAX_WORDS,
   parameter int REL_DEPTH = 4
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [BUFID_W-1:0] iv_free_bufid,
   input  logic               i_free_bufid_wr,
   output logic               o_free_bufid_ack,
   input  logic [DW-1:0]      iv_data,
   input  logic               i_data_wr,
   output logic [DW-1:0]      ov_pkt_data,
   output logic [ADDR_W-1:0]  ov_pkt_waddr,
   output logic               o_pkt_wr,
   output logic [BUFID_W-1:0] ov_desc_bufid,
   output logic [LEN_W-1:0]   ov_desc_len,
   output logic               o_desc_wr,
   input  logic               i_desc_ack,
   output logic [BUFID_W-1:0] ov_rel_bufid,
   output logic               o_rel_bufid_wr,
   input  logic               i_rel_bufid_ack,
   output logic [15:0]        ov_drop_cnt,
   output logic               o_rel_overflow,
   output logic [1:0]         ov_pwc_state
);

   localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(MAX_WORDS);

   pwc_state_e          state, state_nx;
   logic                cache_vld;
   logic [BUFID_W-1:0]  cache_id;
   logic [LEN_W-1:0]    cnt, cnt_nx;
   logic                vld_p1;
   logic [ADDR_W-1:0]   pkt_waddr_p1;
   logic [DW-1:0]       pkt_data_p1;
   logic                free_ack;
   logic                desc_vld;
   logic [BUFID_W-1:0]  desc_id;
   logic [LEN_W-1:0]    desc_len;
   logic [15:0]         drop_cnt;
   logic                rel_ovf;

   logic                sop, eop;
   logic [BUFID_W-1:0]  cur_id;
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic                consume;
   logic                as_idle;
   logic                fin;
   logic [BUFID_W-1:0]  fin_id;
   logic [LEN_W-1:0]    fin_len;
   logic                desc_load;
   logic                rel_a, rel_b;
   logic [BUFID_W-1:0]  rel_b_id;
   logic                drop;
   logic                cache_load;
   logic                rel_empty;
   logic                fifo_ovf;

   assign sop        = iv_data[DW-SOP_OFS];
   assign eop        = iv_data[DW-EOP_OFS];
   // The buffer being written is the upper field of the last write address.
   assign cur_id     = pkt_waddr_p1[ADDR_W-1:OFS_W];
   assign cache_load = !cache_vld && i_free_bufid_wr;

   // Next state and per-word decisions; a sop seen while writing aborts the
   // current packet and is then treated as a fresh start in the same cycle.
   always_comb begin
      state_nx  = state;
      wr_en     = 1'b0;
      wr_addr   = pkt_waddr_p1;
      cnt_nx    = cnt;
      consume   = 1'b0;
      as_idle   = 1'b0;
      fin       = 1'b0;
      fin_id    = cur_id;
      fin_len   = cnt;
      rel_a     = 1'b0;
      rel_b     = 1'b0;
      rel_b_id  = cur_id;
      drop      = 1'b0;
      desc_load = 1'b0;
      if (i_data_wr) begin
         case (state)
            IDLE_S: as_idle = sop;
            WRITE_S: begin
               if (sop) begin
                  rel_a   = 1'b1;
                  drop    = 1'b1;
                  as_idle = 1'b1;
               end else if (cnt != FULL_LEN) begin
                  wr_en   = 1'b1;
                  wr_addr = pkt_waddr_p1 + 16'd1;
                  cnt_nx  = cnt + 8'd1;
                  if (eop) begin
                     fin      = 1'b1;
                     fin_len  = cnt + 8'd1;
                     state_nx = IDLE_S;
                  end
               end else begin
                  rel_a    = 1'b1;
                  drop     = 1'b1;
                  state_nx = eop ? IDLE_S : DISCARD_S;
               end
            end
            DISCARD_S: begin
               if (sop)      as_idle  = 1'b1;
               else if (eop) state_nx = IDLE_S;
            end
            default: state_nx = IDLE_S;
         endcase
         if (as_idle) begin
            if (cache_vld) begin
               wr_en   = 1'b1;
               wr_addr = {cache_id, {OFS_W{1'b0}}};
               cnt_nx  = 8'd1;
               consume = 1'b1;
               fin_id  = cache_id;
               fin_len = 8'd1;
               if (eop) begin
                  fin      = 1'b1;
                  state_nx = IDLE_S;
               end else begin
                  state_nx = WRITE_S;
               end
            end else begin
               drop     = 1'b1;
               state_nx = eop ? IDLE_S : DISCARD_S;
            end
         end
      end
      desc_load = fin && (!desc_vld || i_desc_ack);
      if (fin && !desc_load) begin
         rel_b    = 1'b1;
         rel_b_id = fin_id;
         drop     = 1'b1;
      end
   end

   // FSM state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE_S;
      else          state <= state_nx;
   end

   // Prefetched bufid cache and its take-acknowledge pulse.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cache_vld <= 1'b0;
         cache_id  <= '0;
         free_ack  <= 1'b0;
      end else begin
         free_ack <= cache_load;
         if (cache_load) begin
            cache_vld <= 1'b1;
            cache_id  <= iv_free_bufid;
         end else if (consume) begin
            cache_vld <= 1'b0;
         end
      end
   end

   // Stage p1: registered memory write and running word count.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vld_p1       <= 1'b0;
         pkt_waddr_p1 <= '0;
         pkt_data_p1  <= '0;
         cnt          <= '0;
      end else begin
         vld_p1 <= wr_en;
         cnt    <= cnt_nx;
         if (wr_en) begin
            pkt_waddr_p1 <= wr_addr;
            pkt_data_p1  <= iv_data;
         end
      end
   end

   // Descriptor register: a new load wins over the acknowledge clearing it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         desc_vld <= 1'b0;
         desc_id  <= '0;
         desc_len <= '0;
      end else if (desc_load) begin
         desc_vld <= 1'b1;
         desc_id  <= fin_id;
         desc_len <= fin_len;
      end else if (i_desc_ack) begin
         desc_vld <= 1'b0;
      end
   end

   // Drop counter (at most one step per cycle) and sticky release overflow.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         drop_cnt <= '0;
         rel_ovf  <= 1'b0;
      end else begin
         if (drop)     drop_cnt <= drop_cnt + 16'd1;
         if (fifo_ovf) rel_ovf  <= 1'b1;
      end
   end

   pwc_release_fifo #(
      .W     (BUFID_W),
      .DEPTH (REL_DEPTH)
   ) u_rel_fifo (
      .clk    (i_clk),
      .rst_n  (i_rst_n),
      .push_a (rel_a),
      .din_a  (cur_id),
      .push_b (rel_b),
      .din_b  (rel_b_id),
      .pop    (i_rel_bufid_ack),
      .dout   (ov_rel_bufid),
      .empty  (rel_empty),
      .ovf    (fifo_ovf)
   );

   assign o_free_bufid_ack = free_ack;
   assign o_pkt_wr         = vld_p1;
   assign ov_pkt_waddr     = pkt_waddr_p1;
   assign ov_pkt_data      = pkt_data_p1;
   assign o_desc_wr        = desc_vld;
   assign ov_desc_bufid    = desc_id;
   assign ov_desc_len      = desc_len;
   assign o_rel_bufid_wr   = !rel_empty;
   assign ov_drop_cnt      = drop_cnt;
   assign o_rel_overflow   = rel_ovf;
   assign ov_pwc_state     = state;

endmodule

// File: tb/tb_pkt_write_control.sv
// Bench for pkt_write_control: directed scenarios followed by random
// traffic, every cycle compared against a packet-level reference model.
module tb_pkt_write_control;

   localparam int DW = 134;
   typedef logic [DW-1:0] cv_t;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic [8:0]    iv_free_bufid = '0;
   logic          i_free_bufid_wr = 1'b0;
   logic          o_free_bufid_ack;
   logic [DW-1:0] iv_data = '0;
   logic          i_data_wr = 1'b0;
   logic [DW-1:0] ov_pkt_data;
   logic [15:0]   ov_pkt_waddr;
   logic          o_pkt_wr;
   logic [8:0]    ov_desc_bufid;
   logic [7:0]    ov_desc_len;
   logic          o_desc_wr;
   logic          i_desc_ack = 1'b0;
   logic [8:0]    ov_rel_bufid;
   logic          o_rel_bufid_wr;
   logic          i_rel_bufid_ack = 1'b0;
   logic [15:0]   ov_drop_cnt;
   logic          o_rel_overflow;
   logic [1:0]    ov_pwc_state;

   pkt_write_control #(.DW(DW), .MAX_WORDS(128), .REL_DEPTH(4)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .iv_free_bufid(iv_free_bufid), .i_free_bufid_wr(i_free_bufid_wr),
      .o_free_bufid_ack(o_free_bufid_ack),
      .iv_data(iv_data), .i_data_wr(i_data_wr),
      .ov_pkt_data(ov_pkt_data), .ov_pkt_waddr(ov_pkt_waddr), .o_pkt_wr(o_pkt_wr),
      .ov_desc_bufid(ov_desc_bufid), .ov_desc_len(ov_desc_len), .o_desc_wr(o_desc_wr),
      .i_desc_ack(i_desc_ack),
      .ov_rel_bufid(ov_rel_bufid), .o_rel_bufid_wr(o_rel_bufid_wr),
      .i_rel_bufid_ack(i_rel_bufid_ack),
      .ov_drop_cnt(ov_drop_cnt), .o_rel_overflow(o_rel_overflow),
      .ov_pwc_state(ov_pwc_state)
   );

   always #4 i_clk = ~i_clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input cv_t got, input cv_t exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model, in packet terms.
   bit         m_cache_v;
   logic [8:0] m_cache_id;
   bit         m_in_pkt;    // a buffer is open and being filled
   bit         m_skip;      // ignoring words until eop
   logic [8:0] m_cur;
   int         m_cnt;
   bit         e_ack, e_wr;
   logic [15:0] e_addr;
   cv_t        e_data;
   bit         m_desc_v;
   logic [8:0] m_desc_id;
   int         m_desc_len;
   logic [8:0] m_relq[$];
   logic [15:0] m_drop;
   bit         m_ovf;
   bit         dack_g = 1'b0;
   bit         rack_g = 1'b0;

   task automatic model_reset();
      m_cache_v = 0; m_cache_id = '0; m_in_pkt = 0; m_skip = 0; m_cur = '0; m_cnt = 0;
      e_ack = 0; e_wr = 0; e_addr = '0; e_data = '0;
      m_desc_v = 0; m_desc_id = '0; m_desc_len = 0;
      m_relq.delete(); m_drop = '0; m_ovf = 0;
   endtask

   task automatic model_step();
      bit load, sop, eop, fresh, fin, loaded, drop_now;
      logic [8:0] fin_id;
      int fin_len, room;
      logic [8:0] pend[$];
      load = !m_cache_v && i_free_bufid_wr;
      sop = iv_data[DW-1];
      eop = iv_data[DW-2];
      fresh = 0; fin = 0; loaded = 0; drop_now = 0; fin_id = '0; fin_len = 0;
      e_ack = load;
      e_wr = 0;
      if (i_data_wr) begin
         if (m_in_pkt && sop) begin
            pend.push_back(m_cur); drop_now = 1; m_in_pkt = 0; fresh = 1;
         end else if (m_in_pkt) begin
            if (m_cnt < 128) begin
               e_wr = 1; e_addr = {m_cur, 7'h0} + 16'(m_cnt); e_data = iv_data;
               m_cnt++;
               if (eop) begin m_in_pkt = 0; fin = 1; fin_id = m_cur; fin_len = m_cnt; end
            end else begin
               pend.push_back(m_cur); drop_now = 1; m_in_pkt = 0; m_skip = !eop;
            end
         end else if (sop) fresh = 1;
         else if (eop) m_skip = 0;
         if (fresh) begin
            m_skip = 0;
            if (m_cache_v) begin
               m_cur = m_cache_id; m_cache_v = 0; m_cnt = 1;
               e_wr = 1; e_addr = {m_cur, 7'h0}; e_data = iv_data;
               if (eop) begin fin = 1; fin_id = m_cur; fin_len = 1; end
               else m_in_pkt = 1;
            end else begin
               drop_now = 1; m_skip = !eop;
            end
         end
      end
      if (fin) begin
         if (!m_desc_v || i_desc_ack) begin
            m_desc_v = 1; m_desc_id = fin_id; m_desc_len = fin_len; loaded = 1;
         end else begin
            pend.push_back(fin_id); drop_now = 1;
         end
      end
      if (i_desc_ack && !loaded) m_desc_v = 0;
      room = 4 - m_relq.size();
      if (i_rel_bufid_ack && m_relq.size() > 0) void'(m_relq.pop_front());
      foreach (pend[k]) begin
         if (room > 0) begin m_relq.push_back(pend[k]); room--; end
         else m_ovf = 1;
      end
      if (drop_now) m_drop = m_drop + 16'd1;
      if (load) begin m_cache_v = 1; m_cache_id = i_free_bufid_wr ? iv_free_bufid : '0; end
   endtask

   task automatic compare_outputs();
      int es;
      es = m_in_pkt ? 1 : (m_skip ? 2 : 0);
      check("free_ack", cv_t'(o_free_bufid_ack), cv_t'(e_ack));
      check("pkt_wr", cv_t'(o_pkt_wr), cv_t'(e_wr));
      if (e_wr) begin
         check("pkt_waddr", cv_t'(ov_pkt_waddr), cv_t'(e_addr));
         check("pkt_data", ov_pkt_data, e_data);
      end
      check("desc_wr", cv_t'(o_desc_wr), cv_t'(m_desc_v));
      if (m_desc_v) begin
         check("desc_bufid", cv_t'(ov_desc_bufid), cv_t'(m_desc_id));
         check("desc_len", cv_t'(ov_desc_len), cv_t'(m_desc_len));
      end
      check("rel_wr", cv_t'(o_rel_bufid_wr), cv_t'(m_relq.size() > 0));
      if (m_relq.size() > 0) check("rel_bufid", cv_t'(ov_rel_bufid), cv_t'(m_relq[0]));
      check("drop_cnt", cv_t'(ov_drop_cnt), cv_t'(m_drop));
      check("rel_overflow", cv_t'(o_rel_overflow), cv_t'(m_ovf));
      check("state", cv_t'(ov_pwc_state), cv_t'(es));
   endtask

   task automatic check_reset();
      check("rst_free_ack", cv_t'(o_free_bufid_ack), '0);
      check("rst_pkt_data", ov_pkt_data, '0);
      check("rst_pkt_waddr", cv_t'(ov_pkt_waddr), '0);
      check("rst_pkt_wr", cv_t'(o_pkt_wr), '0);
      check("rst_desc_bufid", cv_t'(ov_desc_bufid), '0);
      check("rst_desc_len", cv_t'(ov_desc_len), '0);
      check("rst_desc_wr", cv_t'(o_desc_wr), '0);
      check("rst_rel_bufid", cv_t'(ov_rel_bufid), '0);
      check("rst_rel_wr", cv_t'(o_rel_bufid_wr), '0);
      check("rst_drop_cnt", cv_t'(ov_drop_cnt), '0);
      check("rst_rel_overflow", cv_t'(o_rel_overflow), '0);
      check("rst_state", cv_t'(ov_pwc_state), '0);
   endtask

   // One clock: drive at the falling edge, model, clock, compare at next fall.
   task automatic step(input bit offer, input logic [8:0] oid, input bit dw,
                       input bit sop, input bit eop);
      logic [159:0] r;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom};
      iv_data = r[DW-1:0];
      iv_data[DW-1] = sop;
      iv_data[DW-2] = eop;
      i_data_wr = dw;
      i_free_bufid_wr = offer;
      iv_free_bufid = offer ? oid : 9'($urandom);
      i_desc_ack = dack_g;
      i_rel_bufid_ack = rack_g;
      model_step();
      @(posedge i_clk);
      @(negedge i_clk);
      compare_outputs();
   endtask

   task automatic send_pkt(input int n, input int offer_at, input logic [8:0] oid);
      for (int i = 0; i < n; i++) step(i == offer_at, oid, 1'b1, i == 0, i == n - 1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 9'h0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge i_clk);
      check_reset();
      i_rst_n = 1'b1;
      compare_outputs();

      // Three-word packet into bufid 0x05.
      step(1'b1, 9'h005, 1'b0, 1'b0, 1'b0);
      check("t1_ack", cv_t'(o_free_bufid_ack), cv_t'(1));
      send_pkt(3, -1, 9'h0);
      check("t1_last_waddr", cv_t'(ov_pkt_waddr), cv_t'(16'h0282));
      idle(1);
      check("t1_desc_bufid", cv_t'(ov_desc_bufid), cv_t'(9'h005));
      check("t1_desc_len", cv_t'(ov_desc_len), cv_t'(3));
      check("t1_no_rel", cv_t'(o_rel_bufid_wr), cv_t'(0));
      dack_g = 1; idle(1); dack_g = 0;

      // Single-word packet into the top buffer.
      step(1'b1, 9'h1FF, 1'b0, 1'b0, 1'b0);
      step(1'b0, 9'h0, 1'b1, 1'b1, 1'b1);
      check("t2_waddr", cv_t'(ov_pkt_waddr), cv_t'(16'hFF80));
      check("t2_desc_len", cv_t'(ov_desc_len), cv_t'(1));
      check("t2_state", cv_t'(ov_pwc_state), cv_t'(0));
      dack_g = 1; idle(1); dack_g = 0;

      // No cached bufid: packet dropped; bufid offered mid-packet used next.
      send_pkt(4, 1, 9'h007);
      check("t3_drop_cnt", cv_t'(ov_drop_cnt), cv_t'(1));
      send_pkt(2, -1, 9'h0);
      check("t3_waddr", cv_t'(ov_pkt_waddr), cv_t'(16'h0381));
      idle(1);
      check("t3_desc_bufid", cv_t'(ov_desc_bufid), cv_t'(9'h007));
      dack_g = 1; idle(1); dack_g = 0;

      // Oversized packet: 128 writes then release.
      step(1'b1, 9'h002, 1'b0, 1'b0, 1'b0);
      send_pkt(130, -1, 9'h0);
      idle(1);
      check("t4_rel_bufid", cv_t'(ov_rel_bufid), cv_t'(9'h002));
      check("t4_drop_cnt", cv_t'(ov_drop_cnt), cv_t'(2));
      check("t4_no_desc", cv_t'(o_desc_wr), cv_t'(0));
      check("t4_last_waddr", cv_t'(ov_pkt_waddr), cv_t'(16'h017F));
      rack_g = 1; idle(1); rack_g = 0;

      // Descriptor held: second completion released, third loads on ack.
      step(1'b1, 9'h008, 1'b0, 1'b0, 1'b0);
      send_pkt(2, -1, 9'h0);
      step(1'b1, 9'h009, 1'b0, 1'b0, 1'b0);
      send_pkt(2, -1, 9'h0);
      check("t5_rel_bufid", cv_t'(ov_rel_bufid), cv_t'(9'h009));
      check("t5_desc_kept", cv_t'(ov_desc_bufid), cv_t'(9'h008));
      check("t5_drop_cnt", cv_t'(ov_drop_cnt), cv_t'(3));
      step(1'b1, 9'h00B, 1'b0, 1'b0, 1'b0);
      step(1'b0, 9'h0, 1'b1, 1'b1, 1'b0);
      dack_g = 1;
      step(1'b0, 9'h0, 1'b1, 1'b0, 1'b1);
      dack_g = 0;
      check("t5_desc_new", cv_t'(ov_desc_bufid), cv_t'(9'h00B));
      check("t5_desc_wr", cv_t'(o_desc_wr), cv_t'(1));
      dack_g = 1; rack_g = 1; idle(1); dack_g = 0; rack_g = 0;

      // Five aborts with releases blocked, then reset mid-packet.
      step(1'b1, 9'h020, 1'b0, 1'b0, 1'b0);
      step(1'b0, 9'h0, 1'b1, 1'b1, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         step(1'b1, 9'(9'h020 + i), 1'b0, 1'b0, 1'b0);
         step(1'b0, 9'h0, 1'b1, 1'b1, 1'b0);
      end
      check("t6_overflow", cv_t'(o_rel_overflow), cv_t'(1));
      check("t6_rel_head", cv_t'(ov_rel_bufid), cv_t'(9'h020));
      check("t6_drop_cnt", cv_t'(ov_drop_cnt), cv_t'(8));
      step(1'b0, 9'h0, 1'b1, 1'b0, 1'b0);
      i_data_wr = 0; i_free_bufid_wr = 0; i_desc_ack = 0; i_rel_bufid_ack = 0;
      #2 i_rst_n = 1'b0;
      #1 check_reset();
      model_reset();
      @(negedge i_clk);
      i_rst_n = 1'b1;
      compare_outputs();

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         dack_g = ($urandom_range(0, 9) < 5);
         rack_g = ($urandom_range(0, 9) < 5);
         step($urandom_range(0, 9) < 3, 9'($urandom), $urandom_range(0, 9) < 7,
              $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 2);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
